display_write_ctrl: RTL and testbench

Sequences CPU port writes into the 16-bit text display memory ({attribute, character} per cell) and shares that single memory port with the display scanout. The CPU programs a cursor address, attribute and character through its port bus; the block turns each character write into one memory write, auto-increments the cursor, and runs a hardware fill/clear engine. Scanout reads always win the memory port; CPU-originated writes take the free cycles.

---
 rtl/display_write_ctrl_if.sv | 26 ++
 rtl/display_write_ctrl.sv | 139 +++++++++++++
 tb/tb_display_write_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/display_write_ctrl_if.sv
// CPU port bus and shared display memory port of the text display write controller.
// The master side drives CPU and scanout requests; the slave side is the controller.
interface display_write_ctrl_if #(
  parameter int ADDR_WIDTH = 11
);
  logic [7:0]            cpuPortId;
  logic                  cpuWriteStrobe;
  logic [7:0]            cpuWriteData;
  logic [7:0]            cpuReadData;
  logic                  scanReq;
  logic [ADDR_WIDTH-1:0] scanAddr;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic                  memWriteEnable;
  logic [15:0]           memWriteData;
  logic                  busy;

  modport master (
    output cpuPortId, cpuWriteStrobe, cpuWriteData, scanReq, scanAddr,
    input  cpuReadData, memAddr, memWriteEnable, memWriteData, busy
  );

  modport slave (
    input  cpuPortId, cpuWriteStrobe, cpuWriteData, scanReq, scanAddr,
    output cpuReadData, memAddr, memWriteEnable, memWriteData, busy
  );
endinterface

// File: rtl/display_write_ctrl.sv
// Turns CPU port writes into text display memory writes (single cell or fill/clear),
// yielding the shared memory port to scanout whenever scanout requests it.
module display_write_ctrl #(
  parameter int         ADDR_WIDTH = 11,
  parameter int         CELLS      = 2000,
  parameter logic [7:0] PORT_BASE  = 8'h00
) (
  input logic clk,
  input logic reset,
  display_write_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITE, FILL} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_CELL  = ADDR_WIDTH'(CELLS - 1);
  localparam logic [15:0]           CELL_COUNT = 16'(CELLS);
  localparam logic [15:0]           BLANK      = 16'h0720;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cursor;
  logic [7:0]            r_att;
  logic [7:0]            r_chr;
  logic [15:0]           r_count;
  logic [15:0]           r_remain;
  logic [15:0]           r_wrData;
  logic                  r_overflow;

  logic [7:0]            w_offset;
  logic                  w_hit;
  logic                  w_wr;
  logic                  w_wrChar;
  logic                  w_wrCmd;
  logic                  w_cmdAbort;
  logic                  w_cmdClear;
  logic                  w_cmdFill;
  logic                  w_busy;
  logic                  w_abortFill;
  logic                  w_writeNow;
  logic [ADDR_WIDTH-1:0] w_cursorNext;

  assign w_offset   = bus.cpuPortId - PORT_BASE;
  assign w_hit      = (w_offset <= 8'd6);
  assign w_wr       = bus.cpuWriteStrobe && w_hit;
  assign w_wrChar   = w_wr && (w_offset == 8'd3);
  assign w_wrCmd    = w_wr && (w_offset == 8'd6);
  assign w_cmdAbort = w_wrCmd && bus.cpuWriteData[2];
  assign w_cmdClear = w_wrCmd && bus.cpuWriteData[1] && !bus.cpuWriteData[2];
  assign w_cmdFill  = w_wrCmd && bus.cpuWriteData[0] && !bus.cpuWriteData[1] && !bus.cpuWriteData[2];

  // An abort arriving mid-fill also suppresses the write of the cycle it arrives in.
  assign w_busy       = (r_state != IDLE);
  assign w_abortFill  = (r_state == FILL) && w_cmdAbort;
  assign w_writeNow   = w_busy && !bus.scanReq && !w_abortFill;
  assign w_cursorNext = (r_cursor >= LAST_CELL) ? '0 : r_cursor + ADDR_WIDTH'(1);

  assign bus.memAddr        = bus.scanReq ? bus.scanAddr : r_cursor;
  assign bus.memWriteEnable = w_writeNow;
  assign bus.memWriteData   = r_wrData;
  assign bus.busy           = w_busy;

  always_comb begin
    bus.cpuReadData = 8'h00;
    if (w_hit) begin
      case (w_offset)
        8'd0:    bus.cpuReadData = {6'b0, r_overflow, w_busy};
        8'd1:    bus.cpuReadData = r_cursor[7:0];
        8'd2:    bus.cpuReadData = {{(16-ADDR_WIDTH){1'b0}}, r_cursor[ADDR_WIDTH-1:8]};
        default: bus.cpuReadData = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_cursor   <= '0;
      r_att      <= 8'h07;
      r_chr      <= 8'h20;
      r_count    <= '0;
      r_remain   <= '0;
      r_wrData   <= BLANK;
      r_overflow <= 1'b0;
    end else begin
      // Overflow clear wins over a drop reported by the same command write.
      if (w_wrCmd && bus.cpuWriteData[7]) begin
        r_overflow <= 1'b0;
      end else if (w_busy && (w_wrChar || w_cmdFill || w_cmdClear)) begin
        r_overflow <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (w_wr) begin
            case (w_offset)
              8'd0: r_cursor[7:0] <= bus.cpuWriteData;
              8'd1: r_cursor[ADDR_WIDTH-1:8] <= bus.cpuWriteData[ADDR_WIDTH-9:0];
              8'd2: r_att <= bus.cpuWriteData;
              8'd3: begin
                r_chr    <= bus.cpuWriteData;
                r_wrData <= {r_att, bus.cpuWriteData};
                r_state  <= WRITE;
              end
              8'd4: r_count[7:0]  <= bus.cpuWriteData;
              8'd5: r_count[15:8] <= bus.cpuWriteData;
              default: ;
            endcase
          end
          if (w_cmdClear) begin
            r_cursor <= '0;
            r_remain <= CELL_COUNT;
            r_wrData <= BLANK;
            r_state  <= FILL;
          end else if (w_cmdFill && (r_count != 16'd0)) begin
            r_remain <= r_count;
            r_wrData <= {r_att, r_chr};
            r_state  <= FILL;
          end
        end
        WRITE: begin
          if (!bus.scanReq) begin
            r_cursor <= w_cursorNext;
            r_state  <= IDLE;
          end
        end
        FILL: begin
          if (w_cmdAbort) begin
            r_state <= IDLE;
          end else if (!bus.scanReq) begin
            r_cursor <= w_cursorNext;
            r_remain <= r_remain - 16'd1;
            if (r_remain == 16'd1) r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_display_write_ctrl.sv
// Directed bench for display_write_ctrl: expected memory writes go into a queue as
// stimulus is driven and are popped and compared by a write monitor.
module tb_display_write_ctrl;

  localparam int AW    = 11;
  localparam int CELLS = 2000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   writeCount;
  logic [AW+15:0] expQ[$];

  display_write_ctrl_if #(.ADDR_WIDTH(AW)) bus();

  display_write_ctrl #(
    .ADDR_WIDTH(AW),
    .CELLS(CELLS),
    .PORT_BASE(8'h00)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and count the outcome.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle CPU port write, launched just after a rising edge.
  task automatic applyStimulus(input logic [7:0] port, input logic [7:0] data);
    @(posedge clk); #1;
    bus.cpuPortId      = port;
    bus.cpuWriteData   = data;
    bus.cpuWriteStrobe = 1'b1;
    @(posedge clk); #1;
    bus.cpuWriteStrobe = 1'b0;
  endtask

  task automatic readPort(input logic [7:0] port, output logic [7:0] data);
    bus.cpuPortId = port;
    #1;
    data = bus.cpuReadData;
  endtask

  task automatic waitIdle(input int budget, output int cycles);
    cycles = 0;
    @(negedge clk);
    while (bus.busy && cycles < budget) begin
      cycles++;
      @(negedge clk);
    end
    if (bus.busy) checkOutput("busy_timeout", 32'd1, 32'd0);
  endtask

  task automatic pushFill(input int start, input int n, input logic [15:0] data);
    for (int i = 0; i < n; i++) begin
      logic [AW-1:0] a;
      a = AW'((start + i) % CELLS);
      expQ.push_back({a, data});
    end
  endtask

  task automatic waitWrites(input int target, input int budget);
    int n;
    n = 0;
    while (writeCount < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (writeCount < target) checkOutput("write_timeout", 32'd1, 32'd0);
  endtask

  // Scoreboard side: every memory write is matched against the next expected cell.
  always @(negedge clk) begin
    if (bus.memWriteEnable) begin
      logic [AW+15:0] e;
      writeCount++;
      checkOutput("we_during_scan", {31'd0, bus.scanReq}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_write", {21'd0, bus.memAddr}, 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkOutput("wr_addr", {21'd0, bus.memAddr}, {21'd0, e[AW+15:16]});
        checkOutput("wr_data", {16'd0, bus.memWriteData}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    logic [7:0] rd;
    int cyc;
    int wc0;

    checks = 0;
    errors = 0;
    writeCount = 0;
    reset = 1'b0;
    bus.cpuPortId = 8'h00;
    bus.cpuWriteStrobe = 1'b0;
    bus.cpuWriteData = 8'h00;
    bus.scanReq = 1'b0;
    bus.scanAddr = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    $display("[TB] reset state");
    readPort(8'd0, rd);
    checkOutput("rst_status", {24'd0, rd}, 32'h00);
    checkOutput("rst_we", {31'd0, bus.memWriteEnable}, 32'd0);
    checkOutput("rst_wdata", {16'd0, bus.memWriteData}, 32'h0720);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);

    $display("[TB] single character write");
    applyStimulus(8'd0, 8'h05);
    applyStimulus(8'd1, 8'h00);
    applyStimulus(8'd2, 8'h1F);
    expQ.push_back({11'd5, 16'h1F41});
    applyStimulus(8'd3, 8'h41);
    @(negedge clk);
    checkOutput("char_we_t1", {31'd0, bus.memWriteEnable}, 32'd1);
    checkOutput("char_busy_t1", {31'd0, bus.busy}, 32'd1);
    waitIdle(20, cyc);
    checkOutput("char_queue_empty", expQ.size(), 32'd0);
    readPort(8'd1, rd);
    checkOutput("char_addrlo", {24'd0, rd}, 32'h06);
    readPort(8'd2, rd);
    checkOutput("char_addrhi", {24'd0, rd}, 32'h00);

    $display("[TB] scanout holds off a pending write");
    expQ.push_back({11'd6, 16'h1F42});
    applyStimulus(8'd3, 8'h42);
    bus.scanReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.scanAddr = AW'(100 + i);
      @(negedge clk);
      checkOutput("scan_we_low", {31'd0, bus.memWriteEnable}, 32'd0);
      checkOutput("scan_addr", {21'd0, bus.memAddr}, 32'(100 + i));
      @(posedge clk); #1;
    end
    bus.scanReq = 1'b0;
    @(negedge clk);
    checkOutput("scan_we_after", {31'd0, bus.memWriteEnable}, 32'd1);
    checkOutput("scan_wr_addr", {21'd0, bus.memAddr}, 32'd6);
    waitIdle(20, cyc);

    $display("[TB] fill across the wrap point");
    applyStimulus(8'd0, 8'hCE);
    applyStimulus(8'd1, 8'h07);
    applyStimulus(8'd4, 8'h04);
    applyStimulus(8'd5, 8'h00);
    pushFill(1998, 4, 16'h1F42);
    wc0 = writeCount;
    applyStimulus(8'd6, 8'h01);
    waitIdle(20, cyc);
    checkOutput("fill_busy_cycles", cyc, 32'd4);
    #1;
    checkOutput("fill_writes", writeCount - wc0, 32'd4);
    checkOutput("fill_queue_empty", expQ.size(), 32'd0);
    readPort(8'd1, rd);
    checkOutput("fill_cursor_lo", {24'd0, rd}, 32'h02);
    readPort(8'd2, rd);
    checkOutput("fill_cursor_hi", {24'd0, rd}, 32'h00);

    $display("[TB] clear with overflow");
    pushFill(0, CELLS, 16'h0720);
    wc0 = writeCount;
    applyStimulus(8'd6, 8'h02);
    applyStimulus(8'd3, 8'h55);
    readPort(8'd0, rd);
    checkOutput("clear_status_ovf", {24'd0, rd}, 32'h03);
    applyStimulus(8'd6, 8'h80);
    readPort(8'd0, rd);
    checkOutput("clear_status_ack", {24'd0, rd}, 32'h01);
    waitIdle(2200, cyc);
    #1;
    checkOutput("clear_writes", writeCount - wc0, CELLS);
    checkOutput("clear_queue_empty", expQ.size(), 32'd0);
    readPort(8'd0, rd);
    checkOutput("clear_status_end", {24'd0, rd}, 32'h00);
    readPort(8'd1, rd);
    checkOutput("clear_cursor_lo", {24'd0, rd}, 32'h00);

    $display("[TB] abort a long fill");
    applyStimulus(8'd0, 8'h2C);
    applyStimulus(8'd1, 8'h01);
    applyStimulus(8'd2, 8'h3A);
    applyStimulus(8'd4, 8'h64);
    applyStimulus(8'd5, 8'h00);
    pushFill(300, 100, 16'h3A42);
    wc0 = writeCount;
    applyStimulus(8'd6, 8'h01);
    waitWrites(wc0 + 10, 50);
    @(posedge clk); #1;
    bus.cpuPortId = 8'd6;
    bus.cpuWriteData = 8'h04;
    bus.cpuWriteStrobe = 1'b1;
    @(negedge clk);
    checkOutput("abort_we_low", {31'd0, bus.memWriteEnable}, 32'd0);
    @(posedge clk); #1;
    bus.cpuWriteStrobe = 1'b0;
    @(negedge clk); #1;
    checkOutput("abort_busy_low", {31'd0, bus.busy}, 32'd0);
    checkOutput("abort_writes", writeCount - wc0, 32'd10);
    checkOutput("abort_queue_left", expQ.size(), 32'd90);
    expQ.delete();
    readPort(8'd1, rd);
    checkOutput("abort_cursor_lo", {24'd0, rd}, 32'h36);
    readPort(8'd2, rd);
    checkOutput("abort_cursor_hi", {24'd0, rd}, 32'h01);

    $display("[TB] reset during fill");
    pushFill(310, 100, 16'h3A42);
    wc0 = writeCount;
    applyStimulus(8'd6, 8'h01);
    waitWrites(wc0 + 5, 50);
    reset = 1'b0;
    #1;
    checkOutput("rstfill_we", {31'd0, bus.memWriteEnable}, 32'd0);
    checkOutput("rstfill_busy", {31'd0, bus.busy}, 32'd0);
    wc0 = writeCount;
    expQ.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("rstfill_no_writes", writeCount - wc0, 32'd0);
    readPort(8'd0, rd);
    checkOutput("rstfill_status", {24'd0, rd}, 32'h00);
    readPort(8'd1, rd);
    checkOutput("rstfill_cursor_lo", {24'd0, rd}, 32'h00);
    readPort(8'd2, rd);
    checkOutput("rstfill_cursor_hi", {24'd0, rd}, 32'h00);
    checkOutput("rstfill_wdata", {16'd0, bus.memWriteData}, 32'h0720);

    $display("[TB] zero-count fill and unmapped ports");
    wc0 = writeCount;
    applyStimulus(8'd6, 8'h01);
    @(negedge clk);
    checkOutput("fill0_busy", {31'd0, bus.busy}, 32'd0);
    #1;
    checkOutput("fill0_writes", writeCount - wc0, 32'd0);
    readPort(8'd3, rd);
    checkOutput("read_port3", {24'd0, rd}, 32'h00);
    readPort(8'd7, rd);
    checkOutput("read_port7", {24'd0, rd}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
